fir_coef_lut_loader: RTL

- Upstream companion of the distributed-arithmetic fir_filter.
- Accepts 64 signed 16-bit tap coefficients over a valid/ready stream.
- Generates all 2048 partial-sum LUT entries (8 groups × 256), one per cycle, in Gray-code order. Each entry needs only one add or subtract.
- Drives the filter's CIN/CADDR/CLOAD load port directly, replacing software precompute.

---
 rtl/fir_coef_lut_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fir_coef_lut_loader.sv
// Collects 64 FIR tap coefficients and streams the 8x256 distributed-arithmetic partial-sum LUT, one Gray-ordered entry per cycle.
// Optional running checksum of written entries: define FIR_COEF_LUT_CHECKSUM_EN.
`timescale 1ns/1ps
module fir_coef_lut_loader #(
   parameter int unsigned NTAPS = 64,
   parameter int unsigned GRP   = 8,
   parameter int unsigned DW    = 16,
   parameter int unsigned LW    = DW + $clog2(GRP),
   parameter int unsigned AW    = $clog2(NTAPS / GRP) + GRP
) (
   input  logic                 clk_slow,
   input  logic                 resetn,
   input  logic [DW-1:0]        coef_in,
   input  logic                 coef_valid,
   output logic                 coef_ready,
   output logic signed [LW-1:0] CIN,
   output logic [AW-1:0]        CADDR,
   output logic                 CLOAD,
   output logic                 busy,
   output logic                 done,
   output logic [LW-1:0]        checksum
);

   localparam int unsigned IW = $clog2(NTAPS);
   localparam int unsigned KW = AW - GRP;
   localparam int unsigned BW = $clog2(GRP);

   typedef enum logic [1:0] {COLLECT, GEN, FIN} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [AW-1:0] n;
   logic [LW-1:0] acc;
   logic [DW-1:0] coef [NTAPS];

   logic [KW-1:0] k;
   logic [GRP-1:0] m;
   logic [GRP-1:0] g;
   logic [BW-1:0] b;
   logic [DW-1:0] sel;
   logic [LW-1:0] c;
   logic [LW-1:0] acc_next;
   logic          accept;
   logic          last_accept;

   assign accept      = coef_valid && coef_ready && (state == COLLECT);
   assign last_accept = accept && (idx == IW'(NTAPS - 1));

   // Gray step: the bit that flips between gray(m-1) and gray(m) is the trailing-zero count of m
   always_comb begin
      k = n[AW-1:GRP];
      m = n[GRP-1:0];
      g = m ^ (m >> 1);
      b = '0;
      for (int i = GRP - 1; i >= 0; i--) begin
         if (m[i]) b = BW'(i);
      end
      sel = coef[{k, b}];
      c   = {{(LW - DW){sel[DW-1]}}, sel};
      if (m == '0)      acc_next = '0;
      else if (g[b])    acc_next = acc + c;
      else              acc_next = acc - c;
   end

   always_ff @(posedge clk_slow or negedge resetn) begin
      if (!resetn) begin
         state      <= COLLECT;
         idx        <= '0;
         n          <= '0;
         acc        <= '0;
         coef_ready <= 1'b0;
         CIN        <= '0;
         CADDR      <= '0;
         CLOAD      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         for (int i = 0; i < int'(NTAPS); i++) coef[i] <= '0;
      end else begin
         case (state)
            COLLECT: begin
               coef_ready <= 1'b1;
               CLOAD      <= 1'b0;
               done       <= 1'b0;
               busy       <= (idx != '0);
               if (accept) begin
                  coef[idx] <= coef_in;
                  idx       <= idx + 1'b1;
                  busy      <= 1'b1;
                  if (last_accept) begin
                     state      <= GEN;
                     n          <= '0;
                     coef_ready <= 1'b0;
                  end
               end
            end
            GEN: begin
               coef_ready <= 1'b0;
               busy       <= 1'b1;
               CIN        <= acc_next;
               CADDR      <= {k, g};
               CLOAD      <= 1'b1;
               acc        <= acc_next;
               n          <= n + 1'b1;
               if (&n) state <= FIN;
            end
            FIN: begin
               CLOAD      <= 1'b0;
               done       <= 1'b1;
               busy       <= 1'b0;
               idx        <= '0;
               coef_ready <= 1'b1;
               state      <= COLLECT;
            end
            default: state <= COLLECT;
         endcase
      end
   end

`ifdef FIR_COEF_LUT_CHECKSUM_EN
   // Modular sum of every entry presented while CLOAD is high
   always_ff @(posedge clk_slow or negedge resetn) begin
      if (!resetn)          checksum <= '0;
      else if (last_accept) checksum <= '0;
      else if (CLOAD)       checksum <= checksum + $unsigned(CIN);
   end
`else
   assign checksum = '0;
`endif

endmodule
